// File: rtl/mem_access_unit_if.sv
// Request/response channel between the execute stage (master) and mem_access_unit (slave).
interface mem_access_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store initiator for a posedge-write / negedge-read data RAM.
// Optional feature: define MEM_BOUNDS_CHECK_EN to reject addresses >= MEM_WORDS with resp_err.
module mem_access_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int MEM_WORDS   = 1024,
  parameter int INIT_CYCLES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_access_unit_if.slave      bus,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  wr_count
);

`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WR,
    S_RD,
    S_RESP
  } state_t;

  state_t              state_reg;
  logic [INIT_W-1:0]   init_cnt_reg;
  logic                out_of_range;

  assign out_of_range = BOUNDS_EN && (32'(bus.req_addr) >= 32'(MEM_WORDS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_INIT;
      init_cnt_reg    <= '0;
      bus.req_ready   <= 1'b0;
      bus.resp_valid  <= 1'b0;
      bus.resp_rdata  <= '0;
      bus.resp_err    <= 1'b0;
      mem_we          <= 1'b0;
      mem_re          <= 1'b0;
      mem_addr        <= '0;
      mem_data        <= '0;
      rd_count        <= '0;
      wr_count        <= '0;
    end else begin
      case (state_reg)
        S_INIT: begin
          if (init_cnt_reg == INIT_W'(INIT_CYCLES - 1)) begin
            state_reg     <= S_IDLE;
            bus.req_ready <= 1'b1;
          end else begin
            init_cnt_reg  <= init_cnt_reg + INIT_W'(1);
          end
        end
        S_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            if (out_of_range) begin
              // Rejected access never touches the RAM and is not counted.
              state_reg      <= S_RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_rdata <= '0;
              bus.resp_err   <= 1'b1;
            end else if (bus.req_write) begin
              state_reg <= S_WR;
              mem_we    <= 1'b1;
              mem_addr  <= bus.req_addr;
              mem_data  <= bus.req_wdata;
            end else begin
              state_reg <= S_RD;
              mem_re    <= 1'b1;
              mem_addr  <= bus.req_addr;
            end
          end
        end
        S_WR: begin
          mem_we         <= 1'b0;
          state_reg      <= S_RESP;
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= '0;
          bus.resp_err   <= 1'b0;
          wr_count       <= wr_count + CNT_WIDTH'(1);
        end
        S_RD: begin
          // mem_q was refreshed by the RAM on the negedge inside this cycle.
          mem_re         <= 1'b0;
          state_reg      <= S_RESP;
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= mem_q;
          bus.resp_err   <= 1'b0;
          rd_count       <= rd_count + CNT_WIDTH'(1);
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
            state_reg      <= S_IDLE;
          end
        end
        default: begin
          state_reg <= S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a posedge-write / negedge-read RAM model.
module tb_mem_access_unit;
  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_q = '0;
  logic [3:0]    rd_count;
  logic [3:0]    wr_count;

  int total = 0;
  int bad = 0;
  int we_pulses = 0;
  int re_pulses = 0;
  bit overlap_seen = 1'b0;
  bit ram_init_done = 1'b0;
  logic [DW-1:0] ram [0:(1<<AW)-1];

  mem_access_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_access_unit #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_WORDS(512),
    .INIT_CYCLES(2), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_re(mem_re),
    .mem_q(mem_q), .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < (1<<AW); i++) ram[i] <= 32'hA000_0000 + 32'(i);
      ram_init_done <= 1'b1;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_data;
    end
  end

  always @(negedge clk) begin
    if (mem_re) mem_q <= ram[mem_addr];
    if (mem_we) we_pulses <= we_pulses + 1;
    if (mem_re) re_pulses <= re_pulses + 1;
    if (mem_we && mem_re) overlap_seen <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // One complete access; called #1 after a posedge. lat = negedges until resp_valid.
  task automatic access(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output logic [DW-1:0] rd, output logic er, output int lat);
    int n;
    n = 0;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.req_ready) check("req_ready_timeout", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.resp_valid && lat < 50);
    if (!bus.resp_valid) check("resp_valid_timeout", 32'(bus.resp_valid), 32'd1);
    rd = bus.resp_rdata; er = bus.resp_err;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic er;
    int lat, wp, rp;

    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.resp_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_mem_we_re", {30'd0, mem_we, mem_re}, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_counts", {24'd0, rd_count, wr_count}, 32'd0);

    // Test 1: init window with req_valid held high from release.
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 10'd4;
    rst_n = 1'b1;
    @(posedge clk); #1; check("init_edge1_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1; check("init_edge2_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1; check("init_hs_ready_drop", 32'(bus.req_ready), 32'd0);
    check("init_rd_strobe", 32'(mem_re), 32'd1);
    bus.req_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    check("init_load_data", bus.resp_rdata, 32'hA000_0004);
    bus.resp_ready = 1'b1; @(posedge clk); #1; bus.resp_ready = 1'b0;
    check("init_rd_count", 32'(rd_count), 32'd1);

    // Test 2: store then load at address 4.
    wp = we_pulses;
    access(1'b1, 10'd4, 32'd1000, rd, er, lat);
    check("st_lat", 32'(lat), 32'd2);
    check("st_rdata_zero", rd, 32'd0);
    check("st_err", 32'(er), 32'd0);
    check("st_we_pulses", 32'(we_pulses - wp), 32'd1);
    access(1'b0, 10'd4, 32'd0, rd, er, lat);
    check("ld_lat", 32'(lat), 32'd2);
    check("ld_rdata", rd, 32'd1000);
    check("ld_counts", {24'd0, rd_count, wr_count}, {24'd0, 4'd2, 4'd1});

    // Test 3: stalled response; a new store request must be ignored.
    wp = we_pulses;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 10'd4;
    @(posedge clk); #1;
    bus.req_write = 1'b1; bus.req_addr = 10'd5; bus.req_wdata = 32'd77;
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(bus.resp_valid), 32'd1);
      check("stall_rdata", bus.resp_rdata, 32'd1000);
      check("stall_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1; @(posedge clk); #1; bus.resp_ready = 1'b0;
    check("stall_no_write", 32'(we_pulses - wp), 32'd0);
    check("stall_ram5", ram[5], 32'hA000_0005);
    check("stall_counts", {24'd0, rd_count, wr_count}, {24'd0, 4'd3, 4'd1});

    // Test 4: reset asserted inside the WR cycle.
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 10'd8;
    bus.req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("wr_we_high", 32'(mem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("rst_we_drop", 32'(mem_we), 32'd0);
    check("rst_mid_ready", 32'(bus.req_ready), 32'd0);
    check("rst_mid_counts", {24'd0, rd_count, wr_count}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    access(1'b0, 10'd8, 32'd0, rd, er, lat);
    check("rst_ram8_kept", rd, 32'hA000_0008);

    // Test 5: load beyond MEM_WORDS=512.
    rp = re_pulses;
    access(1'b0, 10'd600, 32'd0, rd, er, lat);
`ifdef MEM_BOUNDS_CHECK_EN
    check("oob_err", 32'(er), 32'd1);
    check("oob_rdata", rd, 32'd0);
    check("oob_no_re", 32'(re_pulses - rp), 32'd0);
    check("oob_rd_count", 32'(rd_count), 32'd1);
`else
    check("oob_err", 32'(er), 32'd0);
    check("oob_rdata", rd, 32'hA000_0258);
    check("oob_re", 32'(re_pulses - rp), 32'd1);
    check("oob_rd_count", 32'(rd_count), 32'd2);
`endif

    // Test 6: 17 stores wrap the 4-bit wr_count to 1.
    for (int i = 0; i < 17; i++) begin
      access(1'b1, 10'(16 + i), 32'(i), rd, er, lat);
    end
    check("wrap_wr_count", 32'(wr_count), 32'd1);
    access(1'b0, 10'd32, 32'd0, rd, er, lat);
    check("wrap_last_store", rd, 32'd16);
    check("no_we_re_overlap", 32'(overlap_seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
